// File: rtl/game_flow_controller.sv
// Flappy Bird game sequencer. It accumulates bird/pipe overlap per frame, runs the
// READY/PLAY/HIT/OVER flow, gates motion, issues flaps and keeps BCD scores.
module game_flow_controller #(
   parameter int          HIT_FRAMES    = 30,
   parameter int          OVER_FRAMES   = 60,
   parameter logic [11:0] SCORE_MAX_BCD = 12'h999
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic        pix_valid,
   input  logic        pipe_px,
   input  logic        pipe2_px,
   input  logic        bird_px,
   input  logic        bird_oob,
   input  logic        pipe_passed,
   input  logic        btn,
   output logic [1:0]  state,
   output logic        run,
   output logic        bird_en,
   output logic        flap,
   output logic        collide_frame,
   output logic        game_over,
   output logic [11:0] score,
   output logic [11:0] best
);

   localparam int MAX_FRAMES = (HIT_FRAMES > OVER_FRAMES) ? HIT_FRAMES : OVER_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
   localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HIT_FRAMES - 1);
   localparam logic [CNT_W-1:0] OVER_LOAD = CNT_W'(OVER_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_READY = 2'd0,
      ST_PLAY  = 2'd1,
      ST_HIT   = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [11:0]      score_r, score_nxt_s, best_r, best_nxt_s;
   logic             flap_r, flap_nxt_s;
   logic             run_r, run_nxt_s, bird_en_r, bird_en_nxt_s, game_over_r, game_over_nxt_s;
   logic             btn_q_r, acc_r, collide_r;
   logic             rise_s, hit_s, collide_new_s;

   // Saturating three-digit BCD increment with per-digit carry.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v == SCORE_MAX_BCD) begin
         r = v;
      end else if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else if (v[7:4] != 4'd9) begin
         r[3:0] = 4'd0;
         r[7:4] = v[7:4] + 4'd1;
      end else begin
         r[7:0]  = 8'h00;
         r[11:8] = v[11:8] + 4'd1;
      end
      return r;
   endfunction

   assign rise_s        = btn & ~btn_q_r;
   assign hit_s         = pix_valid & bird_px & (pipe_px | pipe2_px);
   // A hit on the tick cycle itself belongs to the frame that is ending.
   assign collide_new_s = acc_r | hit_s | bird_oob;

   // Button edge detect and per-frame collision accumulator.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         btn_q_r   <= 1'b0;
         acc_r     <= 1'b0;
         collide_r <= 1'b0;
      end else begin
         btn_q_r <= btn;
         if (frame_tick) begin
            collide_r <= collide_new_s;
            acc_r     <= 1'b0;
         end else begin
            acc_r <= acc_r | hit_s;
         end
      end
   end

   // Next-state, counter, score and registered-output decode.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      score_nxt_s = score_r;
      best_nxt_s  = best_r;
      flap_nxt_s  = 1'b0;
      case (state_r)
         ST_READY: begin
            if (rise_s) begin
               state_nxt_s = ST_PLAY;
               flap_nxt_s  = 1'b1;
               score_nxt_s = 12'h000;
            end else begin
               state_nxt_s = ST_READY;
            end
         end
         ST_PLAY: begin
            flap_nxt_s = rise_s;
            if (pipe_passed) begin
               score_nxt_s = bcd_inc(score_r);
            end else begin
               score_nxt_s = score_r;
            end
            if (frame_tick && collide_new_s) begin
               state_nxt_s = ST_HIT;
               cnt_nxt_s   = HIT_LOAD;
            end else begin
               state_nxt_s = ST_PLAY;
            end
         end
         ST_HIT: begin
            if (frame_tick && (cnt_r == CNT_ZERO)) begin
               state_nxt_s = ST_OVER;
               cnt_nxt_s   = OVER_LOAD;
               if (score_r > best_r) begin
                  best_nxt_s = score_r;
               end else begin
                  best_nxt_s = best_r;
               end
            end else if (frame_tick) begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_OVER: begin
            if (frame_tick && (cnt_r != CNT_ZERO)) begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
               cnt_nxt_s = cnt_r;
            end
            if (rise_s && (cnt_r == CNT_ZERO)) begin
               state_nxt_s = ST_READY;
            end else begin
               state_nxt_s = ST_OVER;
            end
         end
         default: begin
            state_nxt_s = ST_READY;
         end
      endcase

      run_nxt_s       = 1'b0;
      bird_en_nxt_s   = 1'b0;
      game_over_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_PLAY: begin
            run_nxt_s     = 1'b1;
            bird_en_nxt_s = 1'b1;
         end
         ST_HIT:  bird_en_nxt_s   = 1'b1;
         ST_OVER: game_over_nxt_s = 1'b1;
         default: run_nxt_s       = 1'b0;
      endcase
   end

   // State register and registered outputs.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_r     <= ST_READY;
         cnt_r       <= CNT_ZERO;
         score_r     <= 12'h000;
         best_r      <= 12'h000;
         flap_r      <= 1'b0;
         run_r       <= 1'b0;
         bird_en_r   <= 1'b0;
         game_over_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         score_r     <= score_nxt_s;
         best_r      <= best_nxt_s;
         flap_r      <= flap_nxt_s;
         run_r       <= run_nxt_s;
         bird_en_r   <= bird_en_nxt_s;
         game_over_r <= game_over_nxt_s;
      end
   end

   assign state         = state_r;
   assign run           = run_r;
   assign bird_en       = bird_en_r;
   assign flap          = flap_r;
   assign collide_frame = collide_r;
   assign game_over     = game_over_r;
   assign score         = score_r;
   assign best          = best_r;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: each step drives inputs, clocks once and
// compares outputs against hand-computed values.
module tb_game_flow_controller;

   logic        clk = 1'b0;
   logic        Reset = 1'b0;
   logic        frame_tick = 1'b0, pix_valid = 1'b0, pipe_px = 1'b0, pipe2_px = 1'b0;
   logic        bird_px = 1'b0, bird_oob = 1'b0, pipe_passed = 1'b0, btn = 1'b0;
   logic [1:0]  state;
   logic        run, bird_en, flap, collide_frame, game_over;
   logic [11:0] score, best;

   int total = 0;
   int bad   = 0;
   int flaps = 0;

   game_flow_controller dut (
      .clk(clk), .Reset(Reset), .frame_tick(frame_tick), .pix_valid(pix_valid),
      .pipe_px(pipe_px), .pipe2_px(pipe2_px), .bird_px(bird_px), .bird_oob(bird_oob),
      .pipe_passed(pipe_passed), .btn(btn), .state(state), .run(run), .bird_en(bird_en),
      .flap(flap), .collide_frame(collide_frame), .game_over(game_over),
      .score(score), .best(best)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic frame;
      frame_tick = 1'b1;
      tick;
      frame_tick = 1'b0;
      tick;
   endtask

   initial begin
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_run", 32'(run), 32'd0);
      chk("rst_bird_en", 32'(bird_en), 32'd0);
      chk("rst_flap", 32'(flap), 32'd0);
      chk("rst_collide", 32'(collide_frame), 32'd0);
      chk("rst_over", 32'(game_over), 32'd0);
      chk("rst_score", 32'(score), 32'h000);
      chk("rst_best", 32'(best), 32'h000);
      tick;
      Reset = 1'b1;

      // Idle in READY.
      for (int i = 0; i < 200; i++) begin
         tick;
         if (flap) flaps++;
      end
      chk("idle_flaps", 32'(flaps), 32'd0);
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_run", 32'(run), 32'd0);
      chk("idle_score", 32'(score), 32'h000);

      // Start: btn held for 10 cycles.
      btn = 1'b1;
      tick;
      chk("start_state", 32'(state), 32'd1);
      chk("start_flap", 32'(flap), 32'd1);
      chk("start_run", 32'(run), 32'd1);
      chk("start_bird_en", 32'(bird_en), 32'd1);
      flaps = 0;
      for (int i = 0; i < 9; i++) begin
         tick;
         if (flap) flaps++;
      end
      chk("hold_no_flap", 32'(flaps), 32'd0);
      btn = 1'b0;
      tick;

      // Flap while playing.
      btn = 1'b1;
      tick;
      chk("play_flap", 32'(flap), 32'd1);
      btn = 1'b0;
      tick;
      chk("play_flap_width", 32'(flap), 32'd0);

      // Scoring with BCD carries and saturation.
      for (int i = 0; i < 12; i++) begin
         pipe_passed = 1'b1;
         tick;
         pipe_passed = 1'b0;
         tick;
      end
      chk("score_012", 32'(score), 32'h012);
      pipe_passed = 1'b1;
      for (int i = 0; i < 88; i++) tick;
      chk("score_100", 32'(score), 32'h100);
      for (int i = 0; i < 899; i++) tick;
      chk("score_999", 32'(score), 32'h999);
      for (int i = 0; i < 5; i++) tick;
      chk("score_sat", 32'(score), 32'h999);
      pipe_passed = 1'b0;

      // Clean frame, then one hit pixel mid-frame.
      frame_tick = 1'b1;
      tick;
      frame_tick = 1'b0;
      chk("clean_collide", 32'(collide_frame), 32'd0);
      chk("clean_state", 32'(state), 32'd1);
      pix_valid = 1'b1; bird_px = 1'b1; pipe2_px = 1'b1;
      tick;
      pix_valid = 1'b0; bird_px = 1'b0; pipe2_px = 1'b0;
      tick;
      chk("midframe_state", 32'(state), 32'd1);
      frame_tick = 1'b1;
      tick;
      frame_tick = 1'b0;
      chk("hit_collide", 32'(collide_frame), 32'd1);
      chk("hit_state", 32'(state), 32'd2);
      chk("hit_run", 32'(run), 32'd0);
      chk("hit_bird_en", 32'(bird_en), 32'd1);

      // HIT: 29 ticks stay, rise ignored, 30th tick goes OVER.
      for (int i = 0; i < 29; i++) frame;
      chk("hit_29_state", 32'(state), 32'd2);
      btn = 1'b1;
      tick;
      chk("hit_no_flap", 32'(flap), 32'd0);
      btn = 1'b0;
      tick;
      frame_tick = 1'b1;
      tick;
      frame_tick = 1'b0;
      chk("over_state", 32'(state), 32'd3);
      chk("over_flag", 32'(game_over), 32'd1);
      chk("over_bird_en", 32'(bird_en), 32'd0);
      chk("over_best", 32'(best), 32'h999);

      // OVER: early rise ignored, late rise restarts.
      for (int i = 0; i < 10; i++) frame;
      btn = 1'b1;
      tick;
      btn = 1'b0;
      tick;
      chk("over_early_btn", 32'(state), 32'd3);
      for (int i = 0; i < 50; i++) frame;
      chk("over_wait_state", 32'(state), 32'd3);
      btn = 1'b1;
      tick;
      btn = 1'b0;
      chk("restart_state", 32'(state), 32'd0);
      chk("restart_over", 32'(game_over), 32'd0);
      chk("restart_score_kept", 32'(score), 32'h999);
      tick;
      btn = 1'b1;
      tick;
      btn = 1'b0;
      chk("replay_state", 32'(state), 32'd1);
      chk("replay_score", 32'(score), 32'h000);
      chk("replay_best", 32'(best), 32'h999);
      tick;

      // Hit pixel coincident with frame_tick.
      frame_tick = 1'b1; pix_valid = 1'b1; bird_px = 1'b1; pipe_px = 1'b1;
      tick;
      frame_tick = 1'b0; pix_valid = 1'b0; bird_px = 1'b0; pipe_px = 1'b0;
      chk("tick_hit_state", 32'(state), 32'd2);
      chk("tick_hit_collide", 32'(collide_frame), 32'd1);
      tick;

      // Reset during HIT clears everything, including best.
      Reset = 1'b0;
      #1;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_best", 32'(best), 32'h000);
      tick;
      Reset = 1'b1;
      tick;

      // bird_oob at frame_tick together with a flap rise.
      btn = 1'b1;
      tick;
      btn = 1'b0;
      tick;
      chk("oob_play", 32'(state), 32'd1);
      frame_tick = 1'b1; bird_oob = 1'b1; btn = 1'b1;
      tick;
      frame_tick = 1'b0; bird_oob = 1'b0; btn = 1'b0;
      chk("oob_state", 32'(state), 32'd2);
      chk("oob_flap", 32'(flap), 32'd1);
      chk("oob_collide", 32'(collide_frame), 32'd1);
      tick;
      chk("oob_flap_off", 32'(flap), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer for the Flappy Bird VGA demo.
- Collects per-pixel bird/pipe overlap over each video frame and runs the READY/PLAY/HIT/OVER state machine.
- Gates pipe scrolling and bird physics, issues flap pulses, and keeps the BCD current and best scores for the score renderer.
- Sits between the VGA timing/sprite generators and the pipe/bird motion blocks; supersedes ad-hoc per-pixel status flags.

Parameters:
HIT_FRAMES, 30, frames spent in HIT (bird falls, pipes frozen) before OVER
OVER_FRAMES, 60, frames in OVER before a button press is accepted for restart
SCORE_MAX_BCD, 12'h999, saturation value of score (3 BCD digits)

Ports:
clk  in  1  system/pixel clock; all state updates on posedge
Reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blank
pix_valid  in  1  current pixel inside active video
pipe_px  in  1  pipe set 1 covers current pixel
pipe2_px  in  1  pipe set 2 covers current pixel
bird_px  in  1  bird sprite covers current pixel
bird_oob  in  1  level; bird at ground or ceiling limit
pipe_passed  in  1  one-cycle pulse when a pipe's trailing edge passes bird x
btn  in  1  flap/start button, already synchronised to clk
state  out  2  0=READY 1=PLAY 2=HIT 3=OVER
run  out  1  pipe scroll enable
bird_en  out  1  bird physics enable
flap  out  1  one-cycle flap impulse to bird physics
collide_frame  out  1  registered: collision detected in last completed frame
game_over  out  1  high while state==OVER
score  out  12  current score, 3 BCD digits
best  out  12  best score since reset, 3 BCD digits

Behaviour:
- Reset (async, Reset=0): state=READY; run=0, bird_en=0, flap=0, collide_frame=0, game_over=0; score=0, best=0; accumulator, frame counter, btn_q=0. Reset mid-game clears best as well.
- Button edge: btn_q registers btn; rise = btn & ~btn_q. A level held high gives exactly one rise.
- Collision accumulator:
  - hit = pix_valid & bird_px & (pipe_px | pipe2_px).
  - acc sets on hit.
  - On frame_tick: collide_frame <= acc | hit | bird_oob, then acc clears. A hit coinciding with frame_tick belongs to the ending frame.
  - Accumulation runs in all states; collide_frame is consumed only in PLAY.
- Outputs by state: READY run=0, bird_en=0; PLAY run=1, bird_en=1; HIT run=0, bird_en=1; OVER run=0, bird_en=0, game_over=1.
- READY:
  - rise -> PLAY on the next edge; flap=1 for that same first PLAY cycle; score cleared to 0.
- PLAY:
  - rise -> flap=1 on the following cycle, exactly one cycle wide.
  - pipe_passed -> score += 1 in BCD with per-digit carry (009->010, 099->100); holds at SCORE_MAX_BCD.
  - On frame_tick, if the newly computed collide value is 1 -> HIT. The state change lands on the same edge that updates collide_frame. Frame counter loads HIT_FRAMES-1.
  - pipe_passed coincident with the transition edge still increments score.
- HIT:
  - flap forced 0; rise ignored; score frozen.
  - Each frame_tick decrements the counter; on frame_tick with counter==0 -> OVER.
  - On that same edge, best <= score if score > best (BCD compare = unsigned compare). Counter loads OVER_FRAMES-1.
- OVER:
  - Counter decrements on frame_tick and stops at 0.
  - rise while counter!=0 is ignored and not remembered.
  - rise with counter==0 -> READY; score is kept until the next READY->PLAY.
- Simultaneous events:
  - frame_tick and rise in the same PLAY cycle: flap still issues; the collision check still applies; HIT wins the state.
  - flap issued on that edge still pulses.
- Latency: flap appears 1 cycle after btn is first sampled high. State and collide_frame update 1 cycle after frame_tick.

Test Plan:
- Reset release, no stimulus 200 cycles -> state=0, run=0, bird_en=0, score=000, best=000, flap never high.
- In READY, btn high for 10 cycles -> state=1 one cycle after first sample, single-cycle flap, run=1, bird_en=1; holding btn gives no second flap.
- In PLAY, 12 pipe_passed pulses -> score=012. Preload score to 999 (1000 pulses) -> further pulses keep 999.
- In PLAY, one pixel with bird_px&pipe2_px&pix_valid mid-frame -> at the next frame_tick collide_frame=1, state=2, run=0. After 30 ticks state=3, game_over=1, best=score.
- In OVER, btn rise at tick 10 -> ignored. Btn rise after 60 ticks -> state=0; next rise -> PLAY, score=000, best unchanged.
- Hit pixel on the same cycle as frame_tick, and separately bird_oob=1 at frame_tick -> both enter HIT. Reset asserted during HIT -> immediate READY, best=000.
